// File: rtl/serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_if
//   Handshake and data bundle for the bit-serial add sequencer.
//   Configuration macro: SERIAL_ADDER_SUB_EN adds the `sub` request bit.
//   Signals:
//     start  request, sampled by the sequencer only when busy=0
//     a, b   WIDTH-bit operands, captured on an accepted start
//     cin    carry-in, captured on an accepted start
//     sub    (SERIAL_ADDER_SUB_EN only) subtract request, captured with operands
//     busy   high while bits are being processed
//     done   one-cycle pulse, sum/cout/ovf valid
//     sum    WIDTH-bit result, held until the next accepted start
//     cout   carry out of the MSB
//     ovf    signed overflow
//   Modports: master drives requests (user side), slave is the sequencer.
// -----------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial add sequencer: one 1-bit full_adder cell is reused across a
//   WIDTH-bit operand pair, LSB first, one bit per clock, with a carry
//   flip-flop closing the loop. start/busy/done handshake; the result is held
//   until the next accepted start.
//   Configuration macro: SERIAL_ADDER_SUB_EN -- when defined, the `sub` bit on
//   the interface selects a - b (B captured inverted, carry seeded with 1).
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    serial_adder_ctrl_if.slave (start, a, b, cin, [sub] in;
//            busy, done, sum, cout, ovf out)
//   Parameter WIDTH (>=2) sets operand/result width.
// -----------------------------------------------------------------------------

// 1-bit full adder cell that the sequencer time-multiplexes.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] b_load;
    logic             carry_init;
    logic             fa_s;
    logic             fa_co;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1: invert B on capture and force the carry seed.
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_init = bus.sub | bus.cin;
`else
    assign b_load     = bus.b;
    assign carry_init = bus.cin;
`endif

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // The edge that processes bit WIDTH-1 brings the count to WIDTH.
    assign last_bit = (state == RUN) && (count == LAST_BIT);

    // NOTE: synchronous reset lives inside the clocked block; nothing in the
    // sensitivity list but the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so a
    // missed branch cannot infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Accepting here allows back-to-back operations.
                if (bus.start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath. The operand shift registers are ordinary registers and are
    // cleared on reset along with everything else, so a reset mid-RUN leaves
    // no trace of the discarded operation.
    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            a_sr   <= bus.a;
            b_sr   <= b_load;
            carry  <= carry_init;
            count  <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            // New sum bit enters at the MSB; after WIDTH shifts bit 0 is at [0].
            sum_r  <= {fa_s, sum_r[WIDTH-1:1]};
            carry  <= fa_co;
            count  <= count + 1'b1;
            if (last_bit) begin
                cout_r <= fa_co;
                // carry FF holds the carry into the MSB at this edge.
                ovf_r  <= carry ^ fa_co;
            end
        end
    end

    // Outputs are decoded from registers only.
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=13.
//   Directed vector table, back-to-back and reset-mid-RUN sequences, and
//   randomized operations against an arithmetic reference model.
//   Honours SERIAL_ADDER_SUB_EN when defined.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;
    localparam int W1 = 8;
    localparam int W2 = 13;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(W1)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(W2)) bus13 ();

    serial_adder_ctrl #(.WIDTH(W1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder_ctrl #(.WIDTH(W2)) dut13 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus13)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        int          edge_idx;
    } pend_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sub,
                                    output logic [31:0] s, output logic co, output logic ov);
        logic [63:0] mask;
        logic [63:0] aa;
        logic [63:0] bb;
        logic [63:0] full;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
        full = aa + bb + (sub ? 64'd1 : {63'd0, cin});
        s    = full[31:0] & mask[31:0];
        co   = full[w];
        // Same-sign operands producing a different-sign result.
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    endfunction

    task automatic drive(input int w, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic cin);
        if (w == W1) begin
            bus8.start = st;
            bus8.a     = a[W1-1:0];
            bus8.b     = b[W1-1:0];
            bus8.cin   = cin;
        end else begin
            bus13.start = st;
            bus13.a     = a[W2-1:0];
            bus13.b     = b[W2-1:0];
            bus13.cin   = cin;
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic set_sub(input int w, input logic sub);
        if (w == W1) bus8.sub = sub;
        else         bus13.sub = sub;
    endtask
`endif

    task automatic sample(input int w, output logic busy, output logic done,
                          output logic [31:0] s, output logic co, output logic ov);
        if (w == W1) begin
            busy = bus8.busy; done = bus8.done; s = {24'd0, bus8.sum};
            co = bus8.cout; ov = bus8.ovf;
        end else begin
            busy = bus13.busy; done = bus13.done; s = {19'd0, bus13.sum};
            co = bus13.cout; ov = bus13.ovf;
        end
    endtask

    // One operation from IDLE: 1-cycle start, operand churn and a stray start
    // while busy, then bounded wait for done. Returns results and latency.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input string tag,
                          output logic [31:0] gs, output logic gc, output logic go,
                          output int lat);
        logic        gb;
        logic        gd;
        logic [31:0] hs;
        logic        hc;
        logic        ho;
        @(negedge clk);
        drive(w, 1'b1, a, b, cin);
`ifdef SERIAL_ADDER_SUB_EN
        set_sub(w, sub);
`else
        if (sub) $display("note: sub request ignored in add-only build");
`endif
        @(posedge clk);
        #1;
        drive(w, 1'b0, $urandom, $urandom, 1'(($urandom) & 1));
        sample(w, gb, gd, gs, gc, go);
        check({tag, " busy after accept"}, {31'd0, gb}, 32'd1);
        lat = 0;
        gd  = 1'b0;
        while (!gd && lat < 4 * w) begin
            @(posedge clk);
            #1;
            lat++;
            // Stray start while busy must be ignored.
            if (lat == 2) drive(w, 1'b1, $urandom, $urandom, 1'(($urandom) & 1));
            if (lat == 3) drive(w, 1'b0, $urandom, $urandom, 1'(($urandom) & 1));
            sample(w, gb, gd, gs, gc, go);
        end
        check({tag, " latency"}, lat, w);
        @(posedge clk);
        #1;
        sample(w, gb, gd, hs, hc, ho);
        check({tag, " done single pulse"}, {31'd0, gd}, 32'd0);
        check({tag, " idle after done"}, {31'd0, gb}, 32'd0);
        check({tag, " sum held"}, hs, gs);
    endtask

    initial begin
        vec_t        vecs[7];
        logic [31:0] gs;
        logic        gc;
        logic        go;
        logic [31:0] es;
        logic        ec;
        logic        eo;
        int          lat;
        logic        seen;
        pend_t       q[$];
        pend_t       p;
        logic        expect_busy;
        int          n_done;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(W1, 1'b0, 0, 0, 1'b0);
        drive(W2, 1'b0, 0, 0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        set_sub(W1, 1'b0);
        set_sub(W2, 1'b0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, bus8.busy}, 32'd0);
        check("reset done", {31'd0, bus8.done}, 32'd0);
        check("reset sum", {24'd0, bus8.sum}, 32'd0);
        check("reset cout", {31'd0, bus8.cout}, 32'd0);
        check("reset ovf", {31'd0, bus8.ovf}, 32'd0);
        check("reset busy w13", {31'd0, bus13.busy}, 32'd0);
        check("reset sum w13", {19'd0, bus13.sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            run_op(W1, {24'd0, vecs[i].a}, {24'd0, vecs[i].b}, vecs[i].cin, 1'b0,
                   $sformatf("vec%0d", i), gs, gc, go, lat);
            check($sformatf("vec%0d sum", i), gs, {24'd0, vecs[i].s});
            check($sformatf("vec%0d cout", i), {31'd0, gc}, {31'd0, vecs[i].co});
            check($sformatf("vec%0d ovf", i), {31'd0, go}, {31'd0, vecs[i].ov});
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op(W1, 32'h05, 32'h07, 1'b0, 1'b1, "sub 05-07", gs, gc, go, lat);
        check("sub 05-07 sum", gs, 32'hFE);
        check("sub 05-07 cout", {31'd0, gc}, 32'd0);
        check("sub 05-07 ovf", {31'd0, go}, 32'd0);
        run_op(W1, 32'h80, 32'h01, 1'b1, 1'b1, "sub 80-01", gs, gc, go, lat);
        check("sub 80-01 sum", gs, 32'h7F);
        check("sub 80-01 cout", {31'd0, gc}, 32'd1);
        check("sub 80-01 ovf", {31'd0, go}, 32'd1);
        set_sub(W1, 1'b0);
`endif

        // Start held high for 20 cycles: back-to-back ops, operands churning.
        expect_busy = 1'b0;
        n_done      = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (expect_busy) check("b2b busy after accept", {31'd0, bus8.busy}, 32'd1);
            expect_busy = 1'b0;
            if (bus8.done) begin
                check("b2b pending op at done", {31'd0, q.size() > 0}, 32'd1);
                if (q.size() > 0) begin
                    p = q.pop_front();
                    ref_add(W1, p.a, p.b, p.cin, 1'b0, es, ec, eo);
                    check("b2b sum", {24'd0, bus8.sum}, es);
                    check("b2b cout", {31'd0, bus8.cout}, {31'd0, ec});
                    check("b2b ovf", {31'd0, bus8.ovf}, {31'd0, eo});
                    check("b2b latency", (i - 1) - p.edge_idx, W1);
                    n_done++;
                end
            end
            if (i < 20) drive(W1, 1'b1, $urandom, $urandom, 1'(($urandom) & 1));
            else        drive(W1, 1'b0, 0, 0, 1'b0);
            if (bus8.start && !bus8.busy) begin
                q.push_back('{{24'd0, bus8.a}, {24'd0, bus8.b}, bus8.cin, i});
                expect_busy = 1'b1;
            end
        end
        check("b2b ops drained", q.size(), 0);
        check("b2b ops completed", {31'd0, n_done >= 3}, 32'd1);

        // Reset after 4 bits of an operation.
        @(negedge clk);
        drive(W1, 1'b1, 32'h12, 32'h34, 1'b0);
        @(posedge clk);
        #1;
        drive(W1, 1'b0, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrun reset busy", {31'd0, bus8.busy}, 32'd0);
        check("midrun reset done", {31'd0, bus8.done}, 32'd0);
        check("midrun reset sum", {24'd0, bus8.sum}, 32'd0);
        check("midrun reset cout", {31'd0, bus8.cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus8.done || bus8.busy) seen = 1'b1;
        end
        check("no activity after reset", {31'd0, seen}, 32'd0);

        // Randomized operations at both widths.
        for (int wi = 0; wi < 2; wi++) begin
            int w;
            w = (wi == 0) ? W1 : W2;
            for (int n = 0; n < 1000; n++) begin
                logic [31:0] ra;
                logic [31:0] rb;
                logic        rc;
                logic        rsub;
                ra = $urandom;
                rb = $urandom;
                rc = 1'(($urandom) & 1);
`ifdef SERIAL_ADDER_SUB_EN
                rsub = 1'(($urandom) & 1);
`else
                rsub = 1'b0;
`endif
                ref_add(w, ra, rb, rc, rsub, es, ec, eo);
                run_op(w, ra, rb, rc, rsub, $sformatf("rnd w%0d #%0d", w, n), gs, gc, go, lat);
                check($sformatf("rnd w%0d #%0d sum", w, n), gs, es);
                check($sformatf("rnd w%0d #%0d cout", w, n), {31'd0, gc}, {31'd0, ec});
                check($sformatf("rnd w%0d #%0d ovf", w, n), {31'd0, go}, {31'd0, eo});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
